countdown_ctrl: RTL and testbench
=================================

# countdown_ctrl

Round-timer controller directly downstream of `clock_divider`. It consumes the divider's 10-bit `second` countdown (59→0), restarts it through `resetclock`, and detects each second change and round timeout. It drives a warning flag and a multiplexed, blinking two-digit seven-segment display for the game HUD.

## Interface
- `REFRESH_DIV`, default 100000: clk cycles per display-digit slot (1 kHz at 100 MHz).
- `BLINK_DIV`, default 25000000: clk cycles per blink half-period.
- `WARN_SEC`, default 10: `warning` asserts while running and `second < WARN_SEC`.
- `clk`  in  1  system clock; also clocks `clock_divider`.
- `rst_n`  in  1  asynchronous, active-low reset.
- `second`  in  10  countdown value from `clock_divider`, same clock domain.
- `start`  in  1  level; sampled each cycle, starts or restarts a round.
- `resetclock`  out  1  one-cycle pulse to `clock_divider` to reload 59.
- `tick`  out  1  one-cycle pulse on each `second` change while running.
- `time_up`  out  1  level; high from timeout until the next start.
- `warning`  out  1  level; low-time warning.
- `seg`  out  7  active-low cathodes, bit order {g,f,e,d,c,b,a}.
- `an`  out  4  active-low anodes; `an[0]` is ones, `an[1]` is tens, `an[3:2]` are always high.

## Operation
- FSM states: IDLE, ARM, RUN, TIMEOUT. Reset state is IDLE.
- IDLE: on `start`=1, go to ARM. The display shows "--" (seg = 7'b0111111 on both digits).
- ARM: lasts exactly one cycle.
  - Assert `resetclock`=1.
  - Load `sec_q` ← 59.
  - Clear `time_up`.
  - Go to RUN.
- RUN:
  - Each cycle, register `sec_q` ← `second`.
  - If `second` ≠ `sec_q`, pulse `tick` for that cycle.
  - If that change lands on `second`==0, go to TIMEOUT.
  - If `start`=1, go to ARM. This takes priority over timeout in the same cycle.
- TIMEOUT:
  - Set `time_up`=1. The display freezes at "00".
  - On `start`, go to ARM.
  - Further `second` changes (the divider wraps 0→59) are ignored and produce no `tick`.
- `warning` = (state==RUN) && (`sec_q` < `WARN_SEC`). It is registered.
- Display value:
  - In RUN, the value is `sec_q`. Values >59 saturate to 59.
  - Tens digit is computed by comparison against 10/20/30/40/50. Ones = value − 10·tens.
  - Each digit is encoded with the standard active-low hex font. Only 0–9 are reachable.
- Refresh:
  - The counter runs 0..`REFRESH_DIV`−1.
  - At wrap, the digit select toggles ones↔tens.
  - The selected digit's anode goes low and the others stay high.
- Blink:
  - The counter runs 0..`BLINK_DIV`−1. The blink phase toggles at wrap.
  - In RUN with `warning`=1, or in TIMEOUT, a phase of 0 forces `an`=4'b1111.
  - In all other cases the display is always on.
  - The blink counter and phase reset to 0 on entry to ARM.

## Timing
- Reset values (asynchronous, while `rst_n`=0):
  - state = IDLE.
  - `resetclock`, `tick`, `time_up`, `warning` = 0.
  - `seg` = 7'b1111111, `an` = 4'b1111.
  - All counters = 0, digit select = ones, blink phase = 1.
- From `start` sampled high in IDLE or TIMEOUT:
  - ARM occupies the next cycle, with `resetclock` high for exactly 1 cycle.
  - The divider shows 59 on the cycle after that. Because `sec_q` was preloaded to 59, no spurious `tick` occurs.
- `tick` is registered. It is high the cycle after `second` changes and lasts exactly 1 cycle.
- `time_up` rises in the same cycle as the final `tick` (59→…→0 change).
- `seg`/`an` are registered and update one cycle after a digit-select or value change.
- `start` held high re-enters ARM every other cycle. This is legal: each entry gives a 1-cycle `resetclock` pulse.
- A `rst_n` assertion mid-round aborts immediately. Outputs return to reset values. No `resetclock` is issued until the next `start`.

## Test plan
- Reset, then `start` pulse → `resetclock` high exactly 1 cycle, state RUN, no `tick` while `second` reads 59; display "59".
- Step `second` 59→58→…→10→9 → one `tick` per change; `warning` goes 1 on the cycle after 9 is registered; display blinks at `BLINK_DIV` (use small params, e.g. `REFRESH_DIV`=4, `BLINK_DIV`=16).
- `second` 1→0 → `tick` and `time_up`=1 same cycle; then 0→59 → no `tick`, display stays "00" blinking.
- In TIMEOUT, `start` → `resetclock` pulse, `time_up` clears, `warning` clears, display "59" steady.
- `start` and `second` change to 0 in the same RUN cycle → goes to ARM, `time_up` stays 0.
- `rst_n` low mid-RUN at `second`=23 → `an`=4'b1111, all flags 0 asynchronously. After release, display "--" and no `tick` on `second` changes.

Source files
------------

// File: rtl/countdown_ctrl.sv
// Round-timer controller: follows the clock_divider countdown, flags ticks,
// timeout and low-time warning, and drives a blinking two-digit 7-seg HUD.
module countdown_ctrl #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000,
  parameter int WARN_SEC    = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] second,
  input  logic       start,
  output logic       resetclock,
  output logic       tick,
  output logic       time_up,
  output logic       warning,
  output logic [6:0] seg,
  output logic [3:0] an
);

  typedef enum logic [1:0] {IDLE, ARM, RUN, TIMEOUT} state_t;

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [RW-1:0] REF_LAST   = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [9:0]    WARN_V     = 10'(WARN_SEC);
  localparam logic [6:0]    SEG_DASH   = 7'b0111111;

  state_t        state_q, state_d;
  logic [9:0]    sec_q, sec_d;
  logic          resetclock_q, resetclock_d;
  logic          tick_q, tick_d;
  logic          time_up_q, time_up_d;
  logic          warning_q, warning_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;
  logic [RW-1:0] ref_cnt_q, ref_cnt_d;
  logic          digit_sel_q, digit_sel_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_ph_q, blink_ph_d;

  logic [5:0]    disp_v;
  logic [3:0]    tens, ones;
  logic [6:0]    tens_seg, ones_seg;
  logic          blank;

  function automatic logic [6:0] hex7(input logic [3:0] d);
    case (d)
      4'd0:    hex7 = 7'b1000000;
      4'd1:    hex7 = 7'b1111001;
      4'd2:    hex7 = 7'b0100100;
      4'd3:    hex7 = 7'b0110000;
      4'd4:    hex7 = 7'b0011001;
      4'd5:    hex7 = 7'b0010010;
      4'd6:    hex7 = 7'b0000010;
      4'd7:    hex7 = 7'b1111000;
      4'd8:    hex7 = 7'b0000000;
      4'd9:    hex7 = 7'b0010000;
      4'hA:    hex7 = 7'b0001000;
      4'hB:    hex7 = 7'b0000011;
      4'hC:    hex7 = 7'b1000110;
      4'hD:    hex7 = 7'b0100001;
      4'hE:    hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    state_d      = state_q;
    sec_d        = sec_q;
    resetclock_d = 1'b0;
    tick_d       = 1'b0;
    time_up_d    = time_up_q;
    warning_d    = (state_q == RUN) && (sec_q < WARN_V);
    case (state_q)
      IDLE:    if (start) state_d = ARM;
      ARM: begin
        sec_d   = 10'd59;
        state_d = RUN;
      end
      RUN: begin
        sec_d = second;
        if (second != sec_q) begin
          tick_d = 1'b1;
          if (second == 10'd0) begin
            state_d   = TIMEOUT;
            time_up_d = 1'b1;
          end
        end
        if (start) state_d = ARM;
      end
      TIMEOUT: if (start) state_d = ARM;
      default: state_d = IDLE;
    endcase
    // A restart always wins, so it also cancels a timeout detected this cycle
    if (state_d == ARM) begin
      resetclock_d = 1'b1;
      time_up_d    = 1'b0;
    end
  end

  always_comb begin
    disp_v = (sec_q > 10'd59) ? 6'd59 : sec_q[5:0];
    if (disp_v >= 6'd50) begin
      tens = 4'd5;
      ones = 4'(disp_v - 6'd50);
    end else if (disp_v >= 6'd40) begin
      tens = 4'd4;
      ones = 4'(disp_v - 6'd40);
    end else if (disp_v >= 6'd30) begin
      tens = 4'd3;
      ones = 4'(disp_v - 6'd30);
    end else if (disp_v >= 6'd20) begin
      tens = 4'd2;
      ones = 4'(disp_v - 6'd20);
    end else if (disp_v >= 6'd10) begin
      tens = 4'd1;
      ones = 4'(disp_v - 6'd10);
    end else begin
      tens = 4'd0;
      ones = disp_v[3:0];
    end

    case (state_q)
      IDLE: begin
        tens_seg = SEG_DASH;
        ones_seg = SEG_DASH;
      end
      ARM: begin
        tens_seg = hex7(4'd5);
        ones_seg = hex7(4'd9);
      end
      TIMEOUT: begin
        tens_seg = hex7(4'd0);
        ones_seg = hex7(4'd0);
      end
      default: begin
        tens_seg = hex7(tens);
        ones_seg = hex7(ones);
      end
    endcase
  end

  always_comb begin
    ref_cnt_d   = (ref_cnt_q == REF_LAST) ? '0 : ref_cnt_q + RW'(1);
    digit_sel_d = digit_sel_q ^ (ref_cnt_q == REF_LAST);
    blink_cnt_d = (blink_cnt_q == BLINK_LAST) ? '0 : blink_cnt_q + BW'(1);
    blink_ph_d  = blink_ph_q ^ (blink_cnt_q == BLINK_LAST);
    // Each round starts its blink pattern from a known dark phase
    if (state_d == ARM) begin
      blink_cnt_d = '0;
      blink_ph_d  = 1'b0;
    end
    blank = (((state_q == RUN) && warning_q) || (state_q == TIMEOUT)) && !blink_ph_q;
    seg_d = digit_sel_q ? tens_seg : ones_seg;
    an_d  = blank ? 4'b1111 : (digit_sel_q ? 4'b1101 : 4'b1110);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sec_q        <= '0;
      resetclock_q <= 1'b0;
      tick_q       <= 1'b0;
      time_up_q    <= 1'b0;
      warning_q    <= 1'b0;
      seg_q        <= 7'b1111111;
      an_q         <= 4'b1111;
      ref_cnt_q    <= '0;
      digit_sel_q  <= 1'b0;
      blink_cnt_q  <= '0;
      blink_ph_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      sec_q        <= sec_d;
      resetclock_q <= resetclock_d;
      tick_q       <= tick_d;
      time_up_q    <= time_up_d;
      warning_q    <= warning_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      ref_cnt_q    <= ref_cnt_d;
      digit_sel_q  <= digit_sel_d;
      blink_cnt_q  <= blink_cnt_d;
      blink_ph_q   <= blink_ph_d;
    end
  end

  assign resetclock = resetclock_q;
  assign tick       = tick_q;
  assign time_up    = time_up_q;
  assign warning    = warning_q;
  assign seg        = seg_q;
  assign an         = an_q;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Bench for countdown_ctrl: the bench plays clock_divider, a round-level model
// predicts pulses and flags, and a negedge monitor scores the DUT against it.
module tb_countdown_ctrl;

  localparam int REFRESH_DIV = 4;
  localparam int BLINK_DIV   = 16;
  localparam int WARN_SEC    = 10;
  localparam int DASH        = -1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_in;
  logic [9:0] second_in;
  logic       resetclock, tick, time_up, warning;
  logic [6:0] seg;
  logic [3:0] an;

  always #5 clk = ~clk;

  countdown_ctrl #(
    .REFRESH_DIV(REFRESH_DIV),
    .BLINK_DIV  (BLINK_DIV),
    .WARN_SEC   (WARN_SEC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .second    (second_in),
    .start     (start_in),
    .resetclock(resetclock),
    .tick      (tick),
    .time_up   (time_up),
    .warning   (warning),
    .seg       (seg),
    .an        (an)
  );

  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;
  int tick_exp[$];
  int rc_exp[$];

  localparam int M_IDLE = 0, M_ARM = 1, M_RUN = 2, M_TIMEOUT = 3;
  int mode = M_IDLE;
  int last_sec = 0;
  bit time_up_exp = 1'b0;
  bit warn_exp = 1'b0;

  bit reload_pending = 1'b0;
  int blank_cnt = 0;
  bit got_tens = 1'b0, got_ones = 1'b0;
  logic [6:0] tens_seen = '0, ones_seen = '0;

  function automatic int hex_seg(input int d);
    case (d)
      0:       hex_seg = 7'b1000000;
      1:       hex_seg = 7'b1111001;
      2:       hex_seg = 7'b0100100;
      3:       hex_seg = 7'b0110000;
      4:       hex_seg = 7'b0011001;
      5:       hex_seg = 7'b0010010;
      6:       hex_seg = 7'b0000010;
      7:       hex_seg = 7'b1111000;
      8:       hex_seg = 7'b0000000;
      9:       hex_seg = 7'b0010000;
      default: hex_seg = 7'b0111111;
    endcase
  endfunction

  task automatic check_output(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h at cycle %0d", name, actual, expected, cycle);
    end
  endtask

  // Round-level reference: what the HUD controller must announce after each edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode        = M_IDLE;
      time_up_exp = 1'b0;
      warn_exp    = 1'b0;
      tick_exp.delete();
      rc_exp.delete();
    end else begin
      cycle++;
      warn_exp = (mode == M_RUN) && (last_sec < WARN_SEC);
      case (mode)
        M_IDLE, M_TIMEOUT: if (start_in) mode = M_ARM;
        M_ARM: begin
          mode     = M_RUN;
          last_sec = 59;
        end
        default: begin
          if (int'(second_in) != last_sec) begin
            tick_exp.push_back(cycle);
            if (second_in == 10'd0) begin
              mode        = M_TIMEOUT;
              time_up_exp = 1'b1;
            end
          end
          last_sec = int'(second_in);
          if (start_in) mode = M_ARM;
        end
      endcase
      if (mode == M_ARM) begin
        rc_exp.push_back(cycle);
        time_up_exp = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    check_output("time_up", time_up, time_up_exp);
    check_output("warning", warning, warn_exp);
    while (tick_exp.size() > 0 && tick_exp[0] < cycle) begin
      check_output("tick missing", 0, tick_exp[0]);
      void'(tick_exp.pop_front());
    end
    if (tick === 1'b1) begin
      if (tick_exp.size() > 0 && tick_exp[0] == cycle) begin
        vectors++;
        void'(tick_exp.pop_front());
      end else begin
        check_output("unexpected tick", cycle, -1);
      end
    end
    while (rc_exp.size() > 0 && rc_exp[0] < cycle) begin
      check_output("resetclock missing", 0, rc_exp[0]);
      void'(rc_exp.pop_front());
    end
    if (resetclock === 1'b1) begin
      if (rc_exp.size() > 0 && rc_exp[0] == cycle) begin
        vectors++;
        void'(rc_exp.pop_front());
      end else begin
        check_output("unexpected resetclock", cycle, -1);
      end
    end
  end

  // One cycle of stimulus; second changes model the divider updating on the edge just passed
  task automatic apply_stimulus(input bit st, input bit dec);
    start_in = st;
    if (reload_pending) second_in = 10'd59;
    else if (dec) second_in = (second_in == 10'd0) ? 10'd59 : second_in - 10'd1;
    @(negedge clk);
    if (an == 4'b1111) blank_cnt++;
    if (an == 4'b1110) begin
      ones_seen = seg;
      got_ones  = 1'b1;
    end
    if (an == 4'b1101) begin
      tens_seen = seg;
      got_tens  = 1'b1;
    end
    reload_pending = resetclock;
    @(posedge clk);
    #1;
  endtask

  task automatic count_to(input int target);
    for (int i = 0; i < 200 && int'(second_in) != target; i++) begin
      apply_stimulus(1'b0, 1'b1);
      repeat ($urandom_range(0, 2)) apply_stimulus(1'b0, 1'b0);
    end
  endtask

  task automatic check_digits(input string name, input int t, input int o);
    got_tens = 1'b0;
    got_ones = 1'b0;
    repeat (48) apply_stimulus(1'b0, 1'b0);
    check_output({name, " tens"}, got_tens ? int'(tens_seen) : -2, hex_seg(t));
    check_output({name, " ones"}, got_ones ? int'(ones_seen) : -2, hex_seg(o));
  endtask

  task automatic check_blink(input string name, input bit expect_blink);
    repeat (4) apply_stimulus(1'b0, 1'b0);
    blank_cnt = 0;
    repeat (64) apply_stimulus(1'b0, 1'b0);
    check_output(name, int'(blank_cnt > 0), int'(expect_blink));
  endtask

  task automatic check_reset_outputs(input string name);
    check_output({name, " an"}, an, 4'b1111);
    check_output({name, " seg"}, seg, 7'b1111111);
    check_output({name, " tick"}, tick, 0);
    check_output({name, " resetclock"}, resetclock, 0);
    check_output({name, " time_up"}, time_up, 0);
    check_output({name, " warning"}, warning, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    start_in  = 1'b0;
    second_in = 10'd59;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    repeat (6) apply_stimulus(1'b0, 1'($urandom_range(0, 1)));
    check_digits("idle", DASH, DASH);
    check_blink("idle steady", 1'b0);

    apply_stimulus(1'b1, 1'b0);
    check_digits("start", 5, 9);
    check_blink("run steady", 1'b0);

    count_to(10);
    check_digits("ten", 1, 0);
    count_to(9);
    check_digits("nine", 0, 9);
    check_blink("warning blink", 1'b1);

    count_to(0);
    apply_stimulus(1'b0, 1'b1);
    check_digits("timeout", 0, 0);
    check_blink("timeout blink", 1'b1);

    apply_stimulus(1'b1, 1'b0);
    check_digits("restart", 5, 9);
    check_blink("restart steady", 1'b0);

    count_to(1);
    apply_stimulus(1'b1, 1'b1);
    check_digits("start beats timeout", 5, 9);

    repeat (400) begin
      if ($urandom_range(0, 99) == 0) repeat (5) apply_stimulus(1'b1, 1'b0);
      apply_stimulus(1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 2) == 0));
    end

    apply_stimulus(1'b1, 1'b0);
    count_to(23);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("mid-run reset");
    reload_pending = 1'b0;
    repeat (3) apply_stimulus(1'b0, 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (8) apply_stimulus(1'b0, 1'b1);
    check_digits("after reset", DASH, DASH);

    @(negedge clk);
    #1;
    check_output("tick queue drained", tick_exp.size(), 0);
    check_output("resetclock queue drained", rc_exp.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
